// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side stream engine.
package fifo_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } rd_stream_state_t;

   localparam int STALL_CNT_W = 32;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry output stage: main register plus one skid register, in-order.
// Handshake: a word transfers on a rising edge when valid and ready are both high;
// in_ready comes straight from the skid flop, so it never depends on out_ready.
module stream_skid_buf #(
   parameter int W = 9
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready
);

   logic [W-1:0] skid_data;
   logic         skid_valid;
   logic         main_free;

   assign main_free = !out_valid || out_ready;
   assign in_ready  = !skid_valid;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         out_data   <= '0;
         out_valid  <= 1'b0;
         skid_data  <= '0;
         skid_valid <= 1'b0;
      end else if (main_free) begin
         // Skid is older than any incoming word, so it refills main first.
         if (skid_valid) begin
            out_data   <= skid_data;
            out_valid  <= 1'b1;
            skid_valid <= in_valid;
            if (in_valid) skid_data <= in_data;
         end else begin
            out_valid <= in_valid;
            if (in_valid) out_data <= in_data;
         end
      end else if (in_valid) begin
         skid_data  <= in_data;
         skid_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a show-ahead FIFO into a packetised valid/ready stream with tlast framing.
// Optional underflow stall counter: define FIFO_RD_STREAM_STALL_CNT_EN.
module fifo_rd_stream
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [DATA_WIDTH-1:0] fifo_data_i,
   input  logic                  fifo_empty_i,
   output logic                  fifo_rd_o,
   input  logic [LEN_WIDTH-1:0]  pkt_len_i,
   output logic [DATA_WIDTH-1:0] tdata_o,
   output logic                  tvalid_o,
   input  logic                  tready_i,
   output logic                  tlast_o,
`ifdef FIFO_RD_STREAM_STALL_CNT_EN
   input  logic                  stall_clr_i,
   output logic [STALL_CNT_W-1:0] stall_cnt_o,
`endif
   output logic                  busy_o
);

   rd_stream_state_t     state;
   logic [LEN_WIDTH-1:0] rem;
   logic                 skid_ready;
   logic                 pop;
   logic                 pop_last;
   logic [DATA_WIDTH:0]  out_word;

   assign pop       = (state == RUN) && !fifo_empty_i && skid_ready;
   assign pop_last  = pop && (rem == LEN_WIDTH'(1));
   assign fifo_rd_o = pop;
   assign busy_o    = (state == RUN) || tvalid_o || !skid_ready;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= IDLE;
         rem   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pkt_len_i != '0) begin
                  rem   <= pkt_len_i;
                  state <= RUN;
               end
            end
            RUN: begin
               // Length is resampled on the last pop so packets run back to back.
               if (pop_last) begin
                  rem <= pkt_len_i;
                  if (pkt_len_i == '0) state <= IDLE;
               end else if (pop && rem != '0) begin
                  rem <= rem - LEN_WIDTH'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   stream_skid_buf #(
      .W (DATA_WIDTH + 1)
   ) u_skid (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .in_data   ({pop_last, fifo_data_i}),
      .in_valid  (pop),
      .in_ready  (skid_ready),
      .out_data  (out_word),
      .out_valid (tvalid_o),
      .out_ready (tready_i)
   );

   assign tlast_o = out_word[DATA_WIDTH];
   assign tdata_o = out_word[DATA_WIDTH-1:0];

`ifdef FIFO_RD_STREAM_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] stall_cnt;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         stall_cnt <= '0;
      end else if (stall_clr_i) begin
         stall_cnt <= '0;
      end else if (state == RUN && fifo_empty_i && stall_cnt != '1) begin
         stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      end
   end

   assign stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a show-ahead FIFO model and stream monitor.
module tb_fifo_rd_stream;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic [7:0]  fifo_data_i;
   logic        fifo_empty_i;
   logic        fifo_rd_o;
   logic [15:0] pkt_len_i;
   logic [7:0]  tdata_o;
   logic        tvalid_o;
   logic        tready_i;
   logic        tlast_o;
   logic        busy_o;
`ifdef FIFO_RD_STREAM_STALL_CNT_EN
   logic        stall_clr_i;
   logic [31:0] stall_cnt_o;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [7:0] mem [0:255];
   logic [7:0] wr_ptr = 8'd0;
   logic [7:0] rd_ptr = 8'd0;

   logic [8:0] exp_q[$];
   logic [8:0] rx_q[$];
   int         rx_cyc[$];

   fifo_rd_stream #(.DATA_WIDTH(8), .LEN_WIDTH(16)) dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .fifo_data_i  (fifo_data_i),
      .fifo_empty_i (fifo_empty_i),
      .fifo_rd_o    (fifo_rd_o),
      .pkt_len_i    (pkt_len_i),
      .tdata_o      (tdata_o),
      .tvalid_o     (tvalid_o),
      .tready_i     (tready_i),
      .tlast_o      (tlast_o),
`ifdef FIFO_RD_STREAM_STALL_CNT_EN
      .stall_clr_i  (stall_clr_i),
      .stall_cnt_o  (stall_cnt_o),
`endif
      .busy_o       (busy_o)
   );

   // clock / FIFO model / monitor
   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   assign fifo_empty_i = (wr_ptr == rd_ptr);
   assign fifo_data_i  = mem[rd_ptr];
   always @(posedge clk_i) if (fifo_rd_o) rd_ptr <= rd_ptr + 8'd1;

   always @(negedge clk_i) begin
      if (rst_n_i && tvalid_o && tready_i) begin
         rx_q.push_back({tlast_o, tdata_o});
         rx_cyc.push_back(cyc);
      end
   end

   // driver tasks
   task automatic push_word(input logic [7:0] d);
      mem[wr_ptr] = d;
      wr_ptr = wr_ptr + 8'd1;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic apply_reset();
      rst_n_i   = 1'b0;
      pkt_len_i = 16'd0;
      tready_i  = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      exp_q.delete();
      rx_q.delete();
      rx_cyc.delete();
   endtask

   task automatic wait_rx(input int n, input int budget);
      for (int k = 0; k < budget && rx_q.size() < n; k++) tick();
   endtask

   // scenarios
   task automatic test_reset();
      rst_n_i = 1'b0;
      #3;
      n_tests++; if (tvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b exp 0", tvalid_o); end
      n_tests++; if (tlast_o !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b exp 0", tlast_o); end
      n_tests++; if (tdata_o !== 8'h00) begin n_fail++; $display("FAIL reset_tdata: got %h exp 00", tdata_o); end
      n_tests++; if (fifo_rd_o !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %b exp 0", fifo_rd_o); end
      n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy_o); end
      apply_reset();
   endtask

   task automatic test_basic();
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         push_word(8'h10 + 8'(i));
         exp_q.push_back({(i % 4 == 3), 8'h10 + 8'(i)});
      end
      pkt_len_i = 16'd4;
      tready_i  = 1'b1;
      wait_rx(8, 40);
      n_tests++;
      if (rx_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL basic_count: got %0d exp %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         n_tests++;
         if (rx_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL basic_word[%0d]: got %h exp %h", i, rx_q[i], exp_q[i]);
         end
         n_tests++;
         if (rx_cyc[i] !== rx_cyc[0] + i) begin
            n_fail++; $display("FAIL basic_gap[%0d]: got cycle %0d exp %0d", i, rx_cyc[i], rx_cyc[0] + i);
         end
      end
   endtask

   task automatic test_backpressure();
      int pops_done = 0;
      int hs_done   = 0;
      int occ;
      int stall_pops = 0;
      logic       prev_stall = 1'b0;
      logic [8:0] prev_word  = '0;
      logic       pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         push_word(8'h20 + 8'(i));
         exp_q.push_back({(i % 3 == 2), 8'h20 + 8'(i)});
      end
      pkt_len_i = 16'd3;
      for (int k = 0; k < 40; k++) begin
         tick();
         tready_i = pat[k % 4];
         @(negedge clk_i);
         occ = pops_done - hs_done;
         n_tests++;
         if (tvalid_o !== (occ != 0)) begin
            n_fail++; $display("FAIL bp_tvalid: got %b exp %b (occupancy %0d)", tvalid_o, occ != 0, occ);
         end
         if (occ >= 2) begin
            n_tests++;
            if (fifo_rd_o !== 1'b0) begin n_fail++; $display("FAIL bp_pop_full: got %b exp 0", fifo_rd_o); end
         end
         if (fifo_empty_i) begin
            n_tests++;
            if (fifo_rd_o !== 1'b0) begin n_fail++; $display("FAIL bp_pop_empty: got %b exp 0", fifo_rd_o); end
         end
         if (prev_stall) begin
            n_tests++;
            if ({tvalid_o, tlast_o, tdata_o} !== {1'b1, prev_word}) begin
               n_fail++; $display("FAIL bp_hold: got %b_%h exp 1_%h", tvalid_o, {tlast_o, tdata_o}, prev_word);
            end
         end
         if (!tready_i) begin
            if (tvalid_o && fifo_rd_o) stall_pops++;
            n_tests++;
            if (stall_pops > 1) begin n_fail++; $display("FAIL bp_stall_pops: got %0d exp <=1", stall_pops); end
         end else begin
            stall_pops = 0;
         end
         prev_stall = tvalid_o && !tready_i;
         prev_word  = {tlast_o, tdata_o};
         pops_done += int'(fifo_rd_o);
         hs_done   += int'(tvalid_o && tready_i);
      end
      n_tests++;
      if (rx_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL bp_count: got %0d exp %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         n_tests++;
         if (rx_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL bp_word[%0d]: got %h exp %h", i, rx_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_underflow();
      apply_reset();
      for (int i = 0; i < 5; i++) exp_q.push_back({(i == 4), 8'h30 + 8'(i)});
      push_word(8'h30);
      push_word(8'h31);
      pkt_len_i = 16'd5;
      tready_i  = 1'b1;
      repeat (13) tick();
      n_tests++;
      if (rx_q.size() !== 2) begin n_fail++; $display("FAIL uf_partial: got %0d words exp 2", rx_q.size()); end
      push_word(8'h32);
      push_word(8'h33);
      push_word(8'h34);
      pkt_len_i = 16'd0;
      wait_rx(5, 20);
      repeat (3) tick();
      n_tests++;
      if (rx_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL uf_count: got %0d exp %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         n_tests++;
         if (rx_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL uf_word[%0d]: got %h exp %h", i, rx_q[i], exp_q[i]);
         end
      end
`ifdef FIFO_RD_STREAM_STALL_CNT_EN
      n_tests++;
      if (stall_cnt_o < 32'd9 || stall_cnt_o > 32'd11) begin
         n_fail++; $display("FAIL uf_stall_cnt: got %0d exp 10 +-1", stall_cnt_o);
      end
      stall_clr_i = 1'b1;
      @(negedge clk_i);
      n_tests++;
      if (stall_cnt_o !== 32'd0) begin n_fail++; $display("FAIL uf_stall_clr: got %0d exp 0", stall_cnt_o); end
      tick();
      stall_clr_i = 1'b0;
`endif
   endtask

   task automatic test_len_change();
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         push_word(8'h40 + 8'(i));
         exp_q.push_back({(i == 1 || i == 7), 8'h40 + 8'(i)});
      end
      pkt_len_i = 16'd2;
      tready_i  = 1'b1;
      tick();
      tick();
      pkt_len_i = 16'd6;
      tick();
      tick();
      pkt_len_i = 16'd0;
      n_tests++;
      if (busy_o !== 1'b1) begin n_fail++; $display("FAIL lc_busy_run: got %b exp 1", busy_o); end
      wait_rx(8, 30);
      repeat (3) tick();
      n_tests++;
      if (rx_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL lc_count: got %0d exp %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         n_tests++;
         if (rx_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL lc_word[%0d]: got %h exp %h", i, rx_q[i], exp_q[i]);
         end
      end
      n_tests++;
      if (busy_o !== 1'b0) begin n_fail++; $display("FAIL lc_busy_idle: got %b exp 0", busy_o); end
      push_word(8'h48);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_i);
         n_tests++;
         if (fifo_rd_o !== 1'b0) begin n_fail++; $display("FAIL lc_halt_pop: got %b exp 0", fifo_rd_o); end
         tick();
      end
      pkt_len_i = 16'd1;
      tick();
      pkt_len_i = 16'd0;
      repeat (4) tick();
   endtask

   task automatic test_async_reset();
      apply_reset();
      for (int i = 0; i < 4; i++) push_word(8'h50 + 8'(i));
      pkt_len_i = 16'd3;
      repeat (6) tick();
      n_tests++;
      if (tvalid_o !== 1'b1 || busy_o !== 1'b1) begin
         n_fail++; $display("FAIL ar_pre: got tvalid %b busy %b exp 1 1", tvalid_o, busy_o);
      end
      @(negedge clk_i);
      #2;
      rst_n_i   = 1'b0;
      pkt_len_i = 16'd1;
      #1;
      n_tests++;
      if (tvalid_o !== 1'b0) begin n_fail++; $display("FAIL ar_tvalid: got %b exp 0", tvalid_o); end
      n_tests++;
      if (busy_o !== 1'b0) begin n_fail++; $display("FAIL ar_busy: got %b exp 0", busy_o); end
      tick();
      rst_n_i  = 1'b1;
      tready_i = 1'b1;
      rx_q.delete();
      rx_cyc.delete();
      exp_q.push_back({1'b1, 8'h52});
      exp_q.push_back({1'b1, 8'h53});
      wait_rx(2, 20);
      n_tests++;
      if (rx_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL ar_count: got %0d exp %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         n_tests++;
         if (rx_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL ar_word[%0d]: got %h exp %h", i, rx_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_empty_safety();
      apply_reset();
      pkt_len_i = 16'd1;
      tready_i  = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk_i);
         n_tests++;
         if (fifo_rd_o !== 1'b0 || tvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL empty_safe[%0d]: got rd %b tvalid %b exp 0 0", k, fifo_rd_o, tvalid_o);
         end
      end
      pkt_len_i = 16'd0;
   endtask

   initial begin
      rst_n_i   = 1'b0;
      pkt_len_i = 16'd0;
      tready_i  = 1'b0;
`ifdef FIFO_RD_STREAM_STALL_CNT_EN
      stall_clr_i = 1'b0;
`endif
      test_reset();
      test_basic();
      test_backpressure();
      test_underflow();
      test_len_change();
      test_async_reset();
      test_empty_safety();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side drain engine for the team's show-ahead FIFOs (sc_fifo/dc_fifo read port).
- Pops words from the FIFO and presents them as a valid/ready stream. Each stream packet is framed with tlast after a run-time-programmable number of words.
- A 2-entry skid output stage keeps the downstream ready off the FIFO pop path.
- Sits in the read clock domain, between the FIFO and a stream consumer (DMA, video pipe).

Parameters:
DATA_WIDTH, 8, width of FIFO word and stream data
LEN_WIDTH, 16, width of packet-length field (max packet 2^LEN_WIDTH-1 words)

Ports:
clk_i  in  1  clock; all logic rising-edge
rst_n_i  in  1  reset, asynchronous assert, active-low
fifo_data_i  in  DATA_WIDTH  FIFO head word, valid when fifo_empty_i=0 (show-ahead)
fifo_empty_i  in  1  FIFO empty flag
fifo_rd_o  out  1  pop strobe; head advances next cycle
pkt_len_i  in  LEN_WIDTH  words per packet; sampled at packet boundaries; 0 = halt
tdata_o  out  DATA_WIDTH  stream data
tvalid_o  out  1  stream valid
tready_i  in  1  stream ready
tlast_o  out  1  last word of packet
busy_o  out  1  state is RUN or output stage non-empty

Behaviour:
- Reset (rst_n_i=0, async):
  - Outputs: tvalid_o=0, tlast_o=0, tdata_o=0, fifo_rd_o=0, busy_o=0.
  - Internal: skid empty, state IDLE, remaining-word counter 0.
- FSM:
  - IDLE: if pkt_len_i!=0, load rem=pkt_len_i, go to RUN next cycle.
  - RUN: pop words; rem decrements per pop.
  - On the pop with rem==1:
    - That word is tagged last.
    - pkt_len_i is resampled the same cycle. If non-zero, rem reloads and the FSM stays in RUN (no bubble between packets). If zero, go to IDLE.
- Pop rule (combinational): fifo_rd_o = (state==RUN) && !fifo_empty_i && !skid_valid.
  - fifo_rd_o never depends on tready_i.
  - fifo_rd_o is never asserted while fifo_empty_i=1.
- Output stage:
  - Main register (tdata/tvalid/tlast) plus one skid register.
  - Popped word goes to the main register if it is empty or being consumed (tvalid_o && tready_i). Otherwise it goes to skid.
  - When main is consumed and skid is valid, skid moves to main that cycle. Order is preserved; skid has priority over a new pop. A pop cannot occur while skid is full.
- Latency: word popped at cycle N appears on tdata_o at N+1 when the output is free. Sustained throughput is 1 word/clk with tready_i=1.
- AXI-style hold rule: once tvalid_o=1, tdata_o and tlast_o stay stable until the handshake.
- pkt_len_i changes mid-packet are ignored until the next boundary.
- Packet length 1: every popped word carries tlast.
- FIFO runs dry mid-packet: popping pauses, rem is held, tlast does not fire early, and the packet resumes when data arrives.
- Counter width: rem is LEN_WIDTH bits and never wraps below 0.
- busy_o deasserts only in IDLE with main and skid both empty.

Optional Feature:
- Macro: FIFO_RD_STREAM_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt_o [31:0].
  - Increments each cycle with state==RUN && fifo_empty_i (underflow stall); saturates at all-ones; cleared by reset.
  - Also adds input stall_clr_i, which synchronously zeroes the counter and has priority over increment.
- Undefined: the ports and counter do not exist. Remaining behaviour is identical.

Decomposition:
- Shared package fifo_pkg:
  - typedef enum logic {IDLE, RUN} rd_stream_state_t.
  - Localparam for stall counter width (32).
- One sub-module: stream_skid_buf (DATA_WIDTH+1 payload: data + last, in_valid/in_ready/out_valid/out_ready, registered in_ready).
- Top: FSM, length counter, pop logic, optional stall counter.

Test Plan:
- Basic packet: pkt_len_i=4; FIFO preloaded with 0x10..0x17; tready_i=1 → two packets 0x10-0x13 and 0x14-0x17. tlast on 0x13 and 0x17. One word/clk, no bubble at the boundary.
- Backpressure: pkt_len_i=3; tready_i toggles 1,0,0,1 →
  - no loss or duplication;
  - tdata/tlast stable while stalled;
  - fifo_rd_o=0 whenever skid is full;
  - at most one word popped after tready_i drops.
- Underflow mid-packet: pkt_len_i=5; 2 words written, 10-cycle gap, then 3 words → single packet of 5, tlast only on word 5. With FIFO_RD_STREAM_STALL_CNT_EN, stall_cnt_o=10 (±1 for pipeline edge).
- Length change / halt: set pkt_len_i=2→6 mid-packet → current packet finishes at 2 words, next is 6. Set pkt_len_i=0 → FSM returns to IDLE after the current last word; busy_o falls once the stream drains.
- Async reset mid-packet: assert rst_n_i with skid full →
  - tvalid_o=0 immediately, without waiting for a clock;
  - after release with pkt_len_i=1, each following word carries tlast.
- Empty safety: fifo_empty_i=1 for 100 cycles in RUN → fifo_rd_o stays 0 and tvalid_o stays 0.
